demux_1x4_stream: RTL

Registered 1-to-N stream demultiplexer for the 32-bit ALU datapath. It accepts one valid/ready input stream carrying a select field and routes each beat to one of N_OUT output streams. Each output has its own 2-entry FIFO, so one stalled consumer does not block beats bound for other outputs. It performs the inverse role of the datapath's operand/result multiplexers: it distributes results to destination consumers.

---
 rtl/alu_stream_pkg.sv | 14 +
 rtl/demux_out_fifo.sv | 63 ++++++
 rtl/demux_1x4_stream.sv | 69 ++++++
 3 files changed

// File: rtl/alu_stream_pkg.sv
// rtl/alu_stream_pkg.sv - shared constants and beat type for the ALU result stream mux/demux
package alu_stream_pkg;

  localparam int DEMUX_FIFO_DEPTH = 2;
  localparam int DROP_CNT_W       = 8;
  localparam int BEAT_DATA_W      = 32;
  localparam int BEAT_SEL_W       = 2;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic [BEAT_SEL_W-1:0]  sel;
  } alu_beat_t;

endpackage

// File: rtl/demux_out_fifo.sv
// rtl/demux_out_fifo.sv - 2-entry per-output FIFO with registered head, used by demux_1x4_stream
module demux_out_fifo
  import alu_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int CNT_W = $clog2(DEMUX_FIFO_DEPTH + 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEMUX_FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = head_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case ({do_push, do_pop})
      2'b10: begin
        count_d = count_q + CNT_W'(1);
        if (empty_o) head_d = push_data_i;
        else         tail_d = push_data_i;
      end
      2'b01: begin
        count_d = count_q - CNT_W'(1);
        head_d  = tail_q;
      end
      // Push is only possible when not full, so a concurrent pop means occupancy 1.
      2'b11: head_d = push_data_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/demux_1x4_stream.sv
// rtl/demux_1x4_stream.sv - registered 1-to-N stream demux with per-output FIFOs and drop counter
module demux_1x4_stream
  import alu_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_OUT = 4,
  parameter int SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [DROP_CNT_W-1:0]  drop_cnt
);

  logic [N_OUT-1:0]      full, empty, push, pop;
  logic                  sel_legal, sel_has_room, accept;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // in_ready looks only at registered FIFO fill, never at out_ready.
  always_comb begin
    sel_legal    = 1'b0;
    sel_has_room = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_legal    = 1'b1;
        sel_has_room = !full[k];
      end
    end
  end

  assign in_ready = rst_n && (!sel_legal || sel_has_room);
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign push[k]      = accept && (in_sel == SEL_W'(k));
    assign pop[k]       = out_ready[k] && !empty[k];
    assign out_valid[k] = !empty[k];

    demux_out_fifo #(.WIDTH(WIDTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push[k]),
      .push_data_i(in_data),
      .pop_i      (pop[k]),
      .full_o     (full[k]),
      .empty_o    (empty[k]),
      .head_o     (out_data[k*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && !sel_legal && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

endmodule
